trigger_monitor: RTL and testbench
==================================

Name: trigger_monitor

Overview:
- Receive-side checker for the periodic trigger strobe produced by the team's trigger generator.
- Samples the strobe and measures the spacing between consecutive active cycles (the period).
- Declares lock after a run of periods equal to the expected value, and flags/counts period violations and lost-trigger timeouts.
- Sits at the consumer end of the trigger line, in the same clock domain as the generator.

Parameters:
- EXP_PERIOD, 2, expected strobe period in clk cycles; range 1..2^CNT_W-2.
- LOCK_CNT, 4, consecutive matching periods required to enter LOCKED; range 1..15.
- TIMEOUT, 16, cycles without an event before the trigger is declared lost; must be > EXP_PERIOD and <= 2^CNT_W-1.
- ACTIVE_LOW, 1, 1: trig_in active level is 0; 0: active level is 1.
- CNT_W, 8, width of the gap counter and period output.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- trig_in  input  1  trigger strobe from the generator.
- clr  input  1  synchronous clear of state, counters and err_cnt, active-high.
- evt  output  1  one-cycle pulse per detected event.
- period  output  CNT_W  last measured period.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse on a violation while LOCKED.
- err_cnt  output  8  saturating violation counter.

Behaviour:
- Reset: rst=1 at a rising edge sets state=IDLE, trig_q=inactive level, cnt=0, match_run=0, period=0, evt=0, locked=0, err=0, err_cnt=0. Reset mid-operation aborts everything with no err pulse.
- Input stage: trig_q <= trig_in every cycle. Internal event e = (trig_q == active level). Every active cycle is one event, so a constantly active line gives period 1.
- Gap counter cnt:
  - Cleared to 0 on e.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - Measured value m = cnt + 1, computed before the update and saturating at all-ones.
  - A strobe every N cycles gives m = N.
- Latency: trig_in active at edge k -> e during cycle k..k+1 -> evt, period and state update at edge k+1, i.e. two edges from trig_in to outputs.
- evt <= e whenever state != IDLE or on the first event, i.e. on every event. period <= m on every event except the first one leaving IDLE.
- States and transitions (state, locked, err, err_cnt are all registered):
  - IDLE: on e -> ACQ, match_run=0, cnt=0. No period is measured.
  - ACQ:
    - On e with m == EXP_PERIOD: match_run++. If the new value equals LOCK_CNT -> LOCKED.
    - On e with m != EXP_PERIOD: match_run=0, stay in ACQ, no err.
    - No e and cnt == TIMEOUT-1: -> IDLE, no err.
  - LOCKED:
    - On e with m == EXP_PERIOD: stay.
    - On e with m != EXP_PERIOD: err=1 for one cycle, err_cnt++, -> ACQ, match_run=0.
    - No e and cnt == TIMEOUT-1: err=1, err_cnt++, -> IDLE.
- locked is 1 exactly while state == LOCKED.
- err_cnt saturates at 255. At saturation err still pulses.
- clr: same effect as reset on state, cnt, match_run, period, locked and err_cnt. trig_q is unaffected.
  - clr beats a simultaneous e: the event is ignored, evt=0, state=IDLE.
  - clr beats a simultaneous violation: no err pulse, err_cnt=0.
- Priority: rst > clr > timeout/event logic.

Test Plan:
- Reset: rst=1 for 3 cycles with trig_in toggling -> locked=0, err=0, err_cnt=0, period=0, evt=0 throughout and on the first cycle after release.
- Lock, EXP_PERIOD=2, LOCK_CNT=4: trig_in=0 every 2nd cycle -> evt every 2 cycles, period=2 from the 2nd event, locked rises two edges after the 5th active sample and stays 1.
- Violation while locked: one strobe spacing of 3 -> period=3, err=1 for exactly one cycle, err_cnt=1, locked=0. After 4 further good periods locked=1 again with err_cnt still 1.
- Timeout: while locked, hold trig_in inactive -> err pulse and locked=0 exactly 16 cycles after the last event, err_cnt=1. The next strobe gives evt=1 with period unchanged; the block is back in ACQ.
- Saturation, LOCK_CNT=1: alternate period 2 and period 5 for 260 violations -> err_cnt stops at 255, err still pulses on each violation.
- clr with event: while locked, assert clr in the same cycle e is active -> no evt, no err, locked=0, err_cnt=0, period=0. The next event leaves period=0, and the following one measures the true spacing.

Source files
------------

// File: rtl/trigger_monitor.sv
// Receive-side checker for the periodic trigger strobe: measures spacing
// between events, declares lock after a run of good periods, flags violations.
module trigger_monitor #(
  parameter int EXP_PERIOD = 2,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 16,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  input  logic             clr,
  output logic             evt,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam logic             ACT     = ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0] CMAX    = '1;
  localparam logic [CNT_W-1:0] EXP     = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             trig_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] m;
  logic [3:0]       match_run;
  logic [3:0]       run_n;
  logic             e;
  logic             match;
  logic             tmo;
  logic             viol;
  logic             evt_n;
  logic             err_n;
  logic             locked_n;
  logic             upd_period;

  // trig_q is only reset by rst; clr leaves the input stage alone
  always_ff @(posedge clk) begin
    if (rst) trig_q <= ~ACT;
    else     trig_q <= trig_in;
  end

  assign e     = (trig_q == ACT);
  assign m     = (cnt == CMAX) ? CMAX : cnt + CNT_W'(1);
  assign match = (m == EXP);
  assign tmo   = !e && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    run_n   = match_run;
    viol    = 1'b0;
    unique case (state)
      IDLE: begin
        if (e) begin
          state_n = ACQ;
          run_n   = 4'd0;
        end
      end
      ACQ: begin
        if (e) begin
          if (match) begin
            run_n = match_run + 4'd1;
            if (run_n == LOCK_N) state_n = LOCKED;
          end else begin
            run_n = 4'd0;
          end
        end else if (tmo) begin
          state_n = IDLE;
        end
      end
      LOCKED: begin
        if (e) begin
          if (!match) begin
            viol    = 1'b1;
            state_n = ACQ;
            run_n   = 4'd0;
          end
        end else if (tmo) begin
          viol    = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        run_n   = 4'd0;
      end
    endcase
  end

  always_comb begin
    evt_n      = e;
    err_n      = viol;
    locked_n   = (state_n == LOCKED);
    upd_period = e && (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt       <= '0;
      match_run <= 4'd0;
      period    <= '0;
      evt       <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      if (e)                cnt <= '0;
      else if (cnt != CMAX) cnt <= cnt + CNT_W'(1);
      match_run <= run_n;
      evt       <= evt_n;
      if (upd_period) period <= m;
      locked    <= locked_n;
      err       <= err_n;
      if (viol && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_trigger_monitor.sv
// Directed bench for trigger_monitor: expectations are queued when a strobe
// is driven and compared at the output edge they refer to.
module tb_trigger_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig_a = 1'b1;
  logic       trig_b = 1'b1;
  logic       clr_a = 1'b0;
  logic       clr_b = 1'b0;
  logic       evt_a, evt_b;
  logic [7:0] period_a, period_b;
  logic       locked_a, locked_b;
  logic       err_a, err_b;
  logic [7:0] err_cnt_a, err_cnt_b;

  always #5 clk = ~clk;

  trigger_monitor #(
    .EXP_PERIOD(2), .LOCK_CNT(4), .TIMEOUT(16),
    .ACTIVE_LOW(1'b1), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .trig_in(trig_a), .clr(clr_a),
    .evt(evt_a), .period(period_a), .locked(locked_a),
    .err(err_a), .err_cnt(err_cnt_a)
  );

  trigger_monitor #(
    .EXP_PERIOD(2), .LOCK_CNT(1), .TIMEOUT(16),
    .ACTIVE_LOW(1'b1), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .trig_in(trig_b), .clr(clr_b),
    .evt(evt_b), .period(period_b), .locked(locked_b),
    .err(err_b), .err_cnt(err_cnt_b)
  );

  localparam int S_EVT = 0;
  localparam int S_PER = 1;
  localparam int S_LK  = 2;
  localparam int S_ERR = 3;
  localparam int S_EC  = 4;

  typedef struct {
    int          at;
    int          d;
    int          s;
    logic [31:0] v;
    string       ph;
  } exp_t;

  exp_t  q[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    last_evt = 0;
  string phase = "reset";
  string nm[5] = '{"evt", "period", "locked", "err", "err_cnt"};

  function automatic logic [31:0] get(input int d, input int s);
    logic [31:0] r;
    r = 'x;
    if (d == 0) begin
      case (s)
        S_EVT:   r = {31'b0, evt_a};
        S_PER:   r = {24'b0, period_a};
        S_LK:    r = {31'b0, locked_a};
        S_ERR:   r = {31'b0, err_a};
        default: r = {24'b0, err_cnt_a};
      endcase
    end else begin
      case (s)
        S_EVT:   r = {31'b0, evt_b};
        S_PER:   r = {24'b0, period_b};
        S_LK:    r = {31'b0, locked_b};
        S_ERR:   r = {31'b0, err_b};
        default: r = {24'b0, err_cnt_b};
      endcase
    end
    return r;
  endfunction

  task automatic push(input int at, input int d, input int s,
                      input int v);
    exp_t x;
    x.at = at;
    x.d  = d;
    x.s  = s;
    x.v  = v;
    x.ph = phase;
    q.push_back(x);
  endtask

  task automatic push_all(input int at, input int d, input int ev,
                          input int per, input int lk, input int er,
                          input int ec);
    push(at, d, S_EVT, ev);
    push(at, d, S_PER, per);
    push(at, d, S_LK, lk);
    push(at, d, S_ERR, er);
    push(at, d, S_EC, ec);
  endtask

  task automatic check_due();
    logic [31:0] obs;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at == cyc) begin
        obs = get(q[i].d, q[i].s);
        n_chk++;
        assert (obs === q[i].v) else begin
          n_fail++;
          $error("FAIL %s dut%0d %s @%0d: observed %0d expected %0d",
                 q[i].ph, q[i].d, nm[q[i].s], cyc, obs, q[i].v);
        end
        q.delete(i);
      end
    end
  endtask

  task automatic step(input logic ta, input logic tb_, input logic c);
    trig_a = ta;
    trig_b = tb_;
    clr_a  = c;
    @(posedge clk);
    cyc++;
    #1;
    check_due();
  endtask

  // gap-1 inactive cycles then one active cycle on dut d
  task automatic pulse(input int d, input int gap, input int per,
                       input int lk, input int er, input int ec);
    for (int i = 0; i < gap - 1; i++) begin
      push(cyc + 2, d, S_EVT, 0);
      push(cyc + 2, d, S_ERR, 0);
      step(1'b1, 1'b1, 1'b0);
    end
    push_all(cyc + 2, d, 1, per, lk, er, ec);
    last_evt = cyc + 2;
    if (d == 0) step(1'b0, 1'b1, 1'b0);
    else        step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      push_all(cyc + 1, 0, 0, 0, 0, 0, 0);
      push_all(cyc + 1, 1, 0, 0, 0, 0, 0);
      step(logic'(i % 2 == 0), logic'(i % 2 == 0), 1'b0);
    end
    rst = 1'b0;
    phase = "release";
    push_all(cyc + 1, 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0);

    phase = "lock";
    pulse(0, 2, 0, 0, 0, 0);
    for (int k = 2; k <= 6; k++) pulse(0, 2, 2, int'(k >= 5), 0, 0);

    phase = "violation";
    pulse(0, 3, 3, 0, 1, 1);
    for (int k = 1; k <= 3; k++) pulse(0, 2, 2, 0, 0, 1);
    pulse(0, 2, 2, 1, 0, 1);

    phase = "timeout";
    push(last_evt + 15, 0, S_ERR, 0);
    push(last_evt + 15, 0, S_LK, 1);
    push(last_evt + 16, 0, S_ERR, 1);
    push(last_evt + 16, 0, S_LK, 0);
    push(last_evt + 16, 0, S_EC, 2);
    push(last_evt + 17, 0, S_ERR, 0);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b0);
    pulse(0, 2, 2, 0, 0, 2);
    pulse(0, 3, 3, 0, 0, 2);
    for (int k = 1; k <= 3; k++) pulse(0, 2, 2, 0, 0, 2);
    pulse(0, 2, 2, 1, 0, 2);

    phase = "clr";
    push(cyc + 2, 0, S_EVT, 0);
    step(1'b1, 1'b1, 1'b0);
    push(cyc + 2, 0, S_EVT, 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    push_all(cyc + 1, 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1);
    pulse(0, 2, 0, 0, 0, 0);
    pulse(0, 3, 3, 0, 0, 0);

    phase = "saturate";
    pulse(1, 2, 0, 0, 0, 0);
    pulse(1, 2, 2, 1, 0, 0);
    for (int i = 1; i <= 260; i++) begin
      pulse(1, 5, 5, 0, 1, (i < 255) ? i : 255);
      pulse(1, 2, 2, 1, 0, (i < 255) ? i : 255);
    end

    phase = "drain";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    n_chk++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d pending expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
